grid_write_scheduler: RTL
=========================

// Module: grid_write_scheduler
// PURPOSE
//  Owns the single write port of the 32x32 colour-grid RAM and shares it between two requesters:
//  - decoded SPI colour commands (we/waddr/wdata pulses from the command decoder);
//  - an internal clear engine that sweeps every cell to one colour on game restart.
//  Commands are buffered in a small FIFO. All RAM writes are gated by wr_allow (VGA blanking) to avoid tearing.
// PARAMETERS
//  ADDR_W      10  RAM address width; clear sweeps 0..2^ADDR_W-1
//  DATA_W      8   RAM data width
//  FIFO_DEPTH  4   command FIFO entries; power of 2, >=2
// PORTS
//  clk          in   1       system clock
//  reset        in   1       asynchronous, active-high reset
//  cmd_we       in   1       1-cycle pulse: colour command valid
//  cmd_waddr    in   ADDR_W  command cell address
//  cmd_wdata    in   DATA_W  command cell colour
//  clear_req    in   1       1-cycle pulse: start full-grid clear
//  clear_color  in   DATA_W  colour for clear; sampled with clear_req
//  wr_allow     in   1       1 = RAM writes permitted this cycle (blanking)
//  ram_we       out  1       registered RAM write enable
//  ram_waddr    out  ADDR_W  registered RAM write address
//  ram_wdata    out  DATA_W  registered RAM write data
//  busy         out  1       registered: state CLEAR or FIFO non-empty
//  clear_done   out  1       registered 1-cycle pulse with last clear write
//  overflow     out  1       sticky: a command was dropped on full FIFO
// BEHAVIOUR
//  - Reset (async, any time incl. mid-clear):
//    - state IDLE, FIFO empty, sweep counter 0;
//    - all outputs 0; overflow cleared only by reset.
//  - Enqueue:
//    - cmd_we with FIFO not full: pushes {waddr,wdata} at the clock edge.
//    - cmd_we with FIFO full: command dropped, overflow set.
//    - Push and pop in the same cycle is legal when full: the pop frees the slot, no drop.
//  - FSM IDLE:
//    - wr_allow=1 and FIFO non-empty: pop head; next cycle ram_we=1 with head addr/data.
//    - wr_allow=0: no pop, ram_we=0 next cycle.
//    - Latency: cmd_we in cycle N, FIFO empty, wr_allow high -> ram_we visible in cycle N+2.
//  - clear_req accepted in any state:
//    - go to CLEAR; latch clear_color; sweep counter=0;
//    - FIFO flushed (all entries present before the edge are discarded);
//    - a cmd_we in the same cycle as clear_req is enqueued after the flush and applied after the clear.
//    - clear_req during CLEAR restarts the sweep at 0 with the new colour and flushes again.
//  - FSM CLEAR:
//    - each cycle with wr_allow=1: issue write {counter, latched colour}, counter+1;
//    - wr_allow=0: hold counter, ram_we=0 next cycle.
//    - FIFO never pops in CLEAR; cmd_we still enqueues (deferred until after the clear).
//    - Terminal: write of address 2^ADDR_W-1 -> IDLE.
//    - clear_done=1 in the same output cycle as that final ram_we; counter wraps to 0.
//  - Priority: clear strictly above FIFO; at most one RAM write per cycle.
//  - ram_waddr/ram_wdata hold their last values when ram_we=0.
//  - busy: 1 from the cycle after any push or clear accept until FIFO is empty and state is IDLE.
// TESTING
//  1. Reset; single cmd_we addr=0x021 data=0x05, wr_allow=1
//     -> ram_we exactly 1 cycle at N+2 with 0x021/0x05; busy drops after.
//  2. wr_allow=0; 5 cmd_we (addrs 1..5)
//     -> overflow=1, FIFO full; raise wr_allow -> writes addrs 1,2,3,4 in order, addr 5 never written.
//  3. clear_req colour=0x03, wr_allow=1
//     -> 1024 consecutive writes addr 0..1023, data 0x03; clear_done with addr 1023; then IDLE, busy=0.
//  4. Clear with wr_allow toggling 1/0 every cycle
//     -> 1024 writes, no address skipped or repeated, done after 2047-2048 cycles.
//  5. Queue 3 cmds with wr_allow=0, then clear_req + cmd_we(addr 0x3FF, 0x07) in the same cycle
//     -> the 3 cmds are never written; full clear runs, then single write 0x3FF/0x07.
//  6. Assert reset at counter=500 mid-clear
//     -> outputs 0 immediately; after release, no writes until a new request.

Source files
------------

// File: rtl/grid_write_scheduler.sv
// grid_write_scheduler: arbitrates the colour-grid RAM write port between a command FIFO and a full-grid clear sweep.
module grid_write_scheduler #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_waddr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic              clear_req,
   input  logic [DATA_W-1:0] clear_color,
   input  logic              wr_allow,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              busy,
   output logic              clear_done,
   output logic              overflow
);
   localparam int PW = $clog2(FIFO_DEPTH);
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t state, state_nxt;
   logic [ADDR_W+DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [PW:0] count, count_nxt;
   logic [ADDR_W-1:0] sweep;
   logic [DATA_W-1:0] color;
   logic pop, push, sweep_wr, last;
   // A clear flushes the FIFO but a same-cycle command survives and lands after it.
   always_comb begin
      pop       = state == IDLE && !clear_req && wr_allow && count != '0;
      push      = cmd_we && (clear_req || pop || count != (PW+1)'(FIFO_DEPTH));
      sweep_wr  = state == CLEAR && !clear_req && wr_allow;
      last      = sweep_wr && sweep == '1;
      state_nxt = clear_req ? CLEAR : last ? IDLE : state;
      count_nxt = clear_req ? (PW+1)'(push) : count + (PW+1)'(push) - (PW+1)'(pop);
   end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {cmd_waddr, cmd_wdata};
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state      <= IDLE;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         sweep      <= '0;
         color      <= '0;
         ram_we     <= 1'b0;
         ram_waddr  <= '0;
         ram_wdata  <= '0;
         busy       <= 1'b0;
         clear_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         busy       <= state_nxt == CLEAR || count_nxt != '0;
         clear_done <= last;
         ram_we     <= sweep_wr || pop;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (clear_req) rd_ptr <= wr_ptr;
         else if (pop) rd_ptr <= rd_ptr + PW'(1);
         if (cmd_we && !push) overflow <= 1'b1;
         if (clear_req) begin
            sweep <= '0;
            color <= clear_color;
         end else if (sweep_wr) sweep <= sweep + ADDR_W'(1);
         if (sweep_wr) {ram_waddr, ram_wdata} <= {sweep, color};
         else if (pop) {ram_waddr, ram_wdata} <= mem[rd_ptr];
      end
endmodule
